// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response channel, execute
// redirect input and the decode-facing output handshake.
//   master : fetch unit view (drives requests and decode outputs)
//   slave  : environment view (memory, execute and decode side)
interface fetch_unit_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [XLEN-1:0]        imem_req_addr;
  logic                   imem_resp_valid;
  logic [INSTR_WIDTH-1:0] imem_resp_data;
  logic                   redirect_valid;
  logic [XLEN-1:0]        redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [XLEN-1:0]        out_pc;
  logic [6:0]             out_opcode;
  logic [2:0]             out_funct3;
  logic [11:0]            out_i_imm;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc, out_opcode, out_funct3, out_i_imm,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc, out_opcode, out_funct3, out_i_imm,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Holds the PC, issues one instruction-memory read at a
// time, buffers the returned word and hands it (with its PC and pre-sliced decode
// fields) to decode over a valid/ready handshake. Execute redirects squash any
// stale in-flight or held instruction.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fetch_unit_if.master (imem request/response, redirect, decode output)
module fetch_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     INSTR_WIDTH = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e                 r_state, w_state_d;
  logic [XLEN-1:0]        r_pc, w_pc_d;
  logic [XLEN-1:0]        r_inflight_pc, w_inflight_pc_d;
  logic                   r_squash, w_squash_d;
  logic                   r_hold_valid, w_hold_valid_d;
  logic [INSTR_WIDTH-1:0] r_out_instr, w_out_instr_d;
  logic [XLEN-1:0]        r_out_pc, w_out_pc_d;
  logic [XLEN-1:0]        w_redir_pc;

  // Targets are always word aligned.
  assign w_redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    w_state_d       = r_state;
    w_pc_d          = r_pc;
    w_inflight_pc_d = r_inflight_pc;
    w_squash_d      = r_squash;
    w_hold_valid_d  = r_hold_valid;
    w_out_instr_d   = r_out_instr;
    w_out_pc_d      = r_out_pc;
    unique case (r_state)
      StReq: begin
        if (bus.redirect_valid) begin
          w_pc_d = w_redir_pc;
        end else if (bus.imem_req_ready) begin
          w_inflight_pc_d = r_pc;
          w_state_d       = StWait;
        end
      end
      StWait: begin
        if (bus.imem_resp_valid) begin
          if (!r_squash && !bus.redirect_valid) begin
            w_out_instr_d  = bus.imem_resp_data;
            w_out_pc_d     = r_inflight_pc;
            w_hold_valid_d = 1'b1;
            w_pc_d         = r_inflight_pc + XLEN'(4);
            w_state_d      = StHold;
          end else begin
            // Stale response: drop it and refetch from the (possibly new) pc.
            w_squash_d = 1'b0;
            w_state_d  = StReq;
            if (bus.redirect_valid) w_pc_d = w_redir_pc;
          end
        end else if (bus.redirect_valid) begin
          // Must still absorb the outstanding response before refetching.
          w_pc_d     = w_redir_pc;
          w_squash_d = 1'b1;
        end
      end
      StHold: begin
        if (bus.redirect_valid) begin
          w_hold_valid_d = 1'b0;
          w_pc_d         = w_redir_pc;
          w_state_d      = StReq;
        end else if (bus.out_ready) begin
          w_hold_valid_d = 1'b0;
          w_state_d      = StReq;
        end
      end
      default: w_state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StReq;
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
      r_squash      <= 1'b0;
      r_hold_valid  <= 1'b0;
      r_out_instr   <= '0;
      r_out_pc      <= '0;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_inflight_pc <= w_inflight_pc_d;
      r_squash      <= w_squash_d;
      r_hold_valid  <= w_hold_valid_d;
      r_out_instr   <= w_out_instr_d;
      r_out_pc      <= w_out_pc_d;
    end
  end

  assign bus.imem_req_valid = (r_state == StReq) & ~bus.redirect_valid & ~rst;
  assign bus.imem_req_addr  = r_pc;
  // A redirect cycle is never a decode transfer.
  assign bus.out_valid      = r_hold_valid & ~bus.redirect_valid & ~rst;
  assign bus.out_instr      = r_out_instr;
  assign bus.out_pc         = r_out_pc;
  assign bus.out_opcode     = r_out_instr[6:0];
  assign bus.out_funct3     = r_out_instr[14:12];
  assign bus.out_i_imm      = r_out_instr[31:20];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] ResetPc = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32), .INSTR_WIDTH(32)) bus ();

  fetch_unit #(.XLEN(32), .INSTR_WIDTH(32), .RESET_PC(ResetPc)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int deliveries = 0;

  // Reference state: architectural next pc and a one-deep memory model.
  logic [31:0] exp_pc = ResetPc;
  logic        pend_valid = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          mem_lat = 1;
  logic        spur_en = 1'b0;
  logic        prev_req_stall = 1'b0;
  logic        prev_out_stall = 1'b0;
  logic [31:0] prev_req_addr = '0;
  logic [31:0] prev_out_pc = '0;
  logic [31:0] prev_out_instr = '0;

  // Snapshot of the cycle, taken on the falling edge.
  logic        s_rst, s_req_valid, s_req_ready, s_out_valid, s_out_ready, s_redir;
  logic [31:0] s_req_addr, s_out_pc, s_out_instr, s_redir_pc;
  logic [6:0]  s_opc;
  logic [2:0]  s_f3;
  logic [11:0] s_imm;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h00A0_0093;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_check();
    logic [31:0] w;
    if (s_rst) begin
      check_eq("rst_req_valid", {31'b0, s_req_valid}, 32'd0);
      check_eq("rst_out_valid", {31'b0, s_out_valid}, 32'd0);
      exp_pc = ResetPc;
      pend_valid = 1'b0;
      prev_req_stall = 1'b0;
      prev_out_stall = 1'b0;
      return;
    end
    if (!s_redir) begin
      if (prev_req_stall) begin
        check_eq("req_hold_valid", {31'b0, s_req_valid}, 32'd1);
        check_eq("req_hold_addr", s_req_addr, prev_req_addr);
      end
      if (prev_out_stall) begin
        check_eq("out_hold_valid", {31'b0, s_out_valid}, 32'd1);
        check_eq("out_hold_pc", s_out_pc, prev_out_pc);
        check_eq("out_hold_instr", s_out_instr, prev_out_instr);
      end
    end
    if (s_redir) begin
      check_eq("redir_out_valid", {31'b0, s_out_valid}, 32'd0);
      check_eq("redir_req_valid", {31'b0, s_req_valid}, 32'd0);
      exp_pc = {s_redir_pc[31:2], 2'b00};
    end else begin
      if (s_req_valid) check_eq("req_addr", s_req_addr, exp_pc);
      if (s_req_valid && s_req_ready) begin
        pend_valid = 1'b1;
        pend_addr  = s_req_addr;
        pend_cnt   = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
      end
      if (s_out_valid && s_out_ready) begin
        w = mem_word(exp_pc);
        check_eq("out_pc", s_out_pc, exp_pc);
        check_eq("out_instr", s_out_instr, w);
        check_eq("out_opcode", {25'b0, s_opc}, {25'b0, w[6:0]});
        check_eq("out_funct3", {29'b0, s_f3}, {29'b0, w[14:12]});
        check_eq("out_i_imm", {20'b0, s_imm}, {20'b0, w[31:20]});
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
    end
    prev_req_stall = s_req_valid && !s_req_ready;
    prev_req_addr  = s_req_addr;
    prev_out_stall = s_out_valid && !s_out_ready;
    prev_out_pc    = s_out_pc;
    prev_out_instr = s_out_instr;
  endtask

  task automatic drive_mem();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = $urandom;
    if (pend_valid) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_word(pend_addr);
        pend_valid = 1'b0;
      end
    end else if (spur_en && ($urandom % 16 == 0)) begin
      bus.imem_resp_valid = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    s_rst = rst;
    s_req_valid = bus.imem_req_valid;
    s_req_ready = bus.imem_req_ready;
    s_req_addr = bus.imem_req_addr;
    s_out_valid = bus.out_valid;
    s_out_ready = bus.out_ready;
    s_out_pc = bus.out_pc;
    s_out_instr = bus.out_instr;
    s_opc = bus.out_opcode;
    s_f3 = bus.out_funct3;
    s_imm = bus.out_i_imm;
    s_redir = bus.redirect_valid;
    s_redir_pc = bus.redirect_pc;
    model_check();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic run_until_out(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (s_out_valid) return;
    end
    check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [31:0] pcs [3];
  int          ocyc [3];
  logic [31:0] held_pc;
  int          n;

  initial begin
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.out_ready       = 1'b1;
    @(posedge clk);
    #1;

    // Reset, then back-to-back fetch with a 1-cycle memory.
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("first_req_valid", {31'b0, s_req_valid}, 32'd1);
    check_eq("first_req_addr", s_req_addr, ResetPc);
    check_eq("reset_out_pc", s_out_pc, 32'd0);
    check_eq("reset_out_instr", s_out_instr, 32'd0);
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      step();
      if (s_out_valid) begin
        if (n == 0) begin
          check_eq("addi_opcode", {25'b0, s_opc}, 32'h13);
          check_eq("addi_funct3", {29'b0, s_f3}, 32'h0);
          check_eq("addi_imm", {20'b0, s_imm}, 32'h00A);
        end
        pcs[n] = s_out_pc;
        ocyc[n] = cyc;
        n++;
      end
    end
    check_eq("t1_count", n, 3);
    check_eq("t1_pc0", pcs[0], 32'h100);
    check_eq("t1_pc1", pcs[1], 32'h104);
    check_eq("t1_pc2", pcs[2], 32'h108);
    check_eq("t1_gap01", ocyc[1] - ocyc[0], 3);
    check_eq("t1_gap12", ocyc[2] - ocyc[1], 3);

    // Decode back-pressure in HOLD.
    bus.out_ready = 1'b0;
    run_until_out("t2", 10);
    held_pc = s_out_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t2_out_valid", {31'b0, s_out_valid}, 32'd1);
      check_eq("t2_req_valid", {31'b0, s_req_valid}, 32'd0);
      check_eq("t2_out_pc", s_out_pc, held_pc);
    end
    bus.out_ready = 1'b1;
    step();
    step();
    check_eq("t2_next_req_valid", {31'b0, s_req_valid}, 32'd1);
    check_eq("t2_next_req_addr", s_req_addr, held_pc + 32'd4);

    // Redirect while a request is in flight; the late response is squashed.
    bus.imem_req_ready = 1'b0;
    mem_lat = 3;
    repeat (4) step();
    bus.imem_req_ready = 1'b1;
    step();
    check_eq("t3_accept", {31'b0, s_req_valid}, 32'd1);
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0203;
    step();
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t3_out_valid", {31'b0, s_out_valid}, 32'd0);
      check_eq("t3_req_valid", {31'b0, s_req_valid}, (k == 2) ? 32'd1 : 32'd0);
    end
    check_eq("t3_req_addr", s_req_addr, 32'h200);

    // Redirect in HOLD wins over a ready decode.
    mem_lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b0;
    run_until_out("t4", 10);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0400;
    bus.out_ready = 1'b1;
    step();
    check_eq("t4_out_valid", {31'b0, s_out_valid}, 32'd0);
    bus.redirect_valid = 1'b0;
    step();
    check_eq("t4_req_valid", {31'b0, s_req_valid}, 32'd1);
    check_eq("t4_req_addr", s_req_addr, 32'h400);

    // Request back-pressure, pc wrap, then reset during WAIT.
    bus.imem_req_ready = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t5_stall_valid", {31'b0, s_req_valid}, 32'd1);
      check_eq("t5_stall_addr", s_req_addr, 32'h404);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    step();
    check_eq("t5_wrap_fetch", s_req_addr, 32'hFFFF_FFFC);
    step();
    step();
    check_eq("t5_wrap_out_pc", s_out_pc, 32'hFFFF_FFFC);
    mem_lat = 3;
    step();
    check_eq("t5_wrap_next", s_req_addr, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_eq("t5_rst_req_valid", {31'b0, s_req_valid}, 32'd1);
    check_eq("t5_rst_req_addr", s_req_addr, ResetPc);

    // Randomized traffic against the reference model.
    mem_lat = 0;
    spur_en = 1'b1;
    deliveries = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom % 500 == 0);
      bus.imem_req_ready = ($urandom % 4 != 0);
      bus.out_ready = ($urandom % 4 != 0);
      bus.redirect_valid = ($urandom % 20 == 0);
      bus.redirect_pc = ($urandom % 4 == 0) ? $urandom : 32'h100 + ($urandom % 64);
      step();
    end
    check_eq("random_progress", {31'b0, deliveries > 100}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
